// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan multiplexer.
package seg7_pkg;

    localparam int NDIG = 4;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Pure lookup of the glyph for one hex digit.
    always_comb begin
        seg_o = SEG_OFF;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver with shadowed value update
// at frame boundaries, leading-zero blanking and an anti-ghost gap cycle.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig_sel,
    output logic        upd
);

    localparam logic [15:0] CNT_MAX = SCAN_DIV - 16'd1;

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] disp_q, disp_d;
    logic        pending_q, pending_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  dig_sel_q, dig_sel_d;
    logic        upd_q, upd_d;

    logic        tick;
    logic        frame;
    logic [3:0]  cur_nib;
    logic [6:0]  lut_seg;
    logic [3:0]  lead_zero;

    assign tick  = ena && (cnt_q == CNT_MAX);
    assign frame = tick && (ptr_q == 2'd3);

    seg7_hex_lut u_lut (
        .nib_i (cur_nib),
        .seg_o (lut_seg)
    );

    // Select the nibble of the displayed value for the current digit slot.
    always_comb begin
        cur_nib = disp_q[3:0];
        case (ptr_q)
            2'd0: cur_nib = disp_q[3:0];
            2'd1: cur_nib = disp_q[7:4];
            2'd2: cur_nib = disp_q[11:8];
            2'd3: cur_nib = disp_q[15:12];
            default: cur_nib = disp_q[3:0];
        endcase
    end

    // Digit i is a leading zero when it and every digit to its left are zero;
    // digit 0 always shows so that a zero value still reads "0".
    always_comb begin
        lead_zero    = 4'b0000;
        lead_zero[3] = (disp_q[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'h0);
    end

    // Next-state: prescaler, digit pointer, shadow/display handoff and outputs.
    always_comb begin
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        seg_d     = SEG_OFF;
        dp_d      = 1'b0;
        dig_sel_d = 4'b0000;
        upd_d     = 1'b0;

        if (ena) begin
            if (tick) begin
                // Gap cycle: outputs stay dark while the pointer moves on.
                cnt_d = 16'd0;
                ptr_d = ptr_q + 2'd1;
            end else begin
                cnt_d     = cnt_q + 16'd1;
                dig_sel_d = 4'b0001 << ptr_q;
                seg_d     = (blank_lz && lead_zero[ptr_q]) ? SEG_OFF : lut_seg;
                dp_d      = dp_mask[ptr_q];
            end

            // Handoff uses the old shadow, so a coincident load waits a frame.
            if (frame && pending_q) begin
                disp_d    = shadow_q;
                pending_d = 1'b0;
                upd_d     = 1'b1;
            end

            if (load) begin
                shadow_d  = value;
                pending_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 16'd0;
            ptr_q     <= 2'd0;
            shadow_q  <= 16'd0;
            disp_q    <= 16'd0;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b0;
            dig_sel_q <= 4'b0000;
            upd_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_sel_q <= dig_sel_d;
            upd_q     <= upd_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign dig_sel = dig_sel_q;
    assign upd     = upd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux with SCAN_DIV=4.
module tb_seg7_scan_mux;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_mask = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_sel;
    logic        upd;

    seg7_scan_mux #(.SCAN_DIV(16'd4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .seg      (seg),
        .dp       (dp),
        .dig_sel  (dig_sel),
        .upd      (upd)
    );

    always #5 clk = ~clk;

    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: time is counted as enabled cycles since reset.
    int          m_e;
    logic [15:0] m_disp, m_shadow;
    logic        m_pend;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_upd;
    logic [3:0]  exp_dig;

    int          n_total = 0;
    int          n_fail = 0;
    int          upd_seen = 0;
    logic [6:0]  obs_seg [4];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int          slot, digit;
        logic [15:0] sh;
        logic [3:0]  nib;
        exp_seg = 7'h00; exp_dp = 1'b0; exp_dig = 4'b0000; exp_upd = 1'b0;
        if (!rst_n) begin
            m_e = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
        end else if (ena) begin
            slot  = m_e % DIV;
            digit = (m_e / DIV) % 4;
            if (slot != DIV - 1) begin
                sh      = m_disp >> (4 * digit);
                nib     = sh[3:0];
                exp_dig = 4'(1 << digit);
                exp_seg = (blank_lz && digit != 0 && sh == 16'h0) ? 7'h00 : HEX[nib];
                exp_dp  = dp_mask[digit];
            end
            if ((m_e % (4 * DIV)) == 4 * DIV - 1 && m_pend) begin
                m_disp  = m_shadow;
                m_pend  = 1'b0;
                exp_upd = 1'b1;
            end
            if (load) begin
                m_shadow = value;
                m_pend   = 1'b1;
            end
            m_e++;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("seg", 16'(seg), 16'(exp_seg));
        chk("dp", 16'(dp), 16'(exp_dp));
        chk("dig_sel", 16'(dig_sel), 16'(exp_dig));
        chk("upd", 16'(upd), 16'(exp_upd));
        if (upd) upd_seen++;
        for (int i = 0; i < 4; i++)
            if (dig_sel == 4'(1 << i)) obs_seg[i] = seg;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_once(input logic [15:0] v);
        load = 1'b1; value = v;
        cycle();
        load = 1'b0;
    endtask

    task automatic align_boundary();
        for (int i = 0; i < 4 * DIV && (m_e % (4 * DIV)) != 4 * DIV - 1; i++) cycle();
    endtask

    initial begin
        m_e = 0; m_disp = 0; m_shadow = 0; m_pend = 0;
        for (int i = 0; i < 4; i++) obs_seg[i] = 7'h00;

        // Reset state.
        run(2);
        chk("rst_dig_sel", 16'(dig_sel), 16'h0);
        chk("rst_seg", 16'(seg), 16'h0);

        // Release: first cycle shows digit 0 as "0", then the full scan pattern.
        rst_n = 1'b1;
        cycle();
        chk("first_dig_sel", 16'(dig_sel), 16'h1);
        chk("first_seg", 16'(seg), 16'h3F);
        run(31);

        // Mid-frame load: applied once at the next frame boundary.
        run(5);
        upd_seen = 0;
        load_once(16'h12AF);
        run(40);
        chk("upd_once", 16'(upd_seen), 16'd1);
        chk("d0_F", 16'(obs_seg[0]), 16'h71);
        chk("d1_A", 16'(obs_seg[1]), 16'h77);
        chk("d2_2", 16'(obs_seg[2]), 16'h5B);
        chk("d3_1", 16'(obs_seg[3]), 16'h06);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load_once(16'h0040);
        run(40);
        chk("lz_d0", 16'(obs_seg[0]), 16'h3F);
        chk("lz_d1", 16'(obs_seg[1]), 16'h66);
        chk("lz_d2", 16'(obs_seg[2]), 16'h00);
        chk("lz_d3", 16'(obs_seg[3]), 16'h00);
        load_once(16'h0000);
        run(40);
        chk("z_d0", 16'(obs_seg[0]), 16'h3F);
        chk("z_d1", 16'(obs_seg[1]), 16'h00);
        chk("z_d3", 16'(obs_seg[3]), 16'h00);
        blank_lz = 1'b0;

        // Load coinciding with the frame boundary.
        run(3);
        load_once(16'h1111);
        upd_seen = 0;
        align_boundary();
        load_once(16'h2222);
        run(5);
        chk("coinc_old_shadow", 16'(obs_seg[0]), 16'h06);
        run(40);
        chk("coinc_upd_twice", 16'(upd_seen), 16'd2);
        chk("coinc_new", 16'(obs_seg[3]), 16'h5B);

        // Enable dropped mid-slot for 10 cycles.
        for (int i = 0; i < DIV && (m_e % DIV) != 1; i++) cycle();
        ena = 1'b0;
        run(10);
        chk("off_dig_sel", 16'(dig_sel), 16'h0);
        ena = 1'b1;
        run(20);

        // Reset while an update is pending.
        dp_mask = 4'b0100;
        load_once(16'h9876);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        upd_seen = 0;
        run(40);
        chk("rst_abort_upd", 16'(upd_seen), 16'd0);
        chk("rst_abort_d3", 16'(obs_seg[3]), 16'h3F);
        chk("rst_abort_d2", 16'(obs_seg[2]), 16'h3F);

        // Randomized operation against the model.
        for (int i = 0; i < 600; i++) begin
            ena      = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 19) == 0);
            value    = 16'($urandom);
            blank_lz = 1'($urandom);
            dp_mask  = 4'($urandom);
            rst_n    = ($urandom_range(0, 199) != 0);
            cycle();
        end
        load = 1'b0; rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd25, giving clk cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port ena, input, 1 bit: run enable.
REQ-005 SHALL have port load, input, 1 bit: single-cycle request to capture value.
REQ-006 SHALL have port value, input, 16 bits: four hex nibbles; [3:0] is digit 0, the rightmost.
REQ-007 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-008 SHALL have port dp_mask, input, 4 bits: decimal point per digit; bit i is digit i.
REQ-009 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active high.
REQ-010 SHALL have port dp, output, 1 bit: decimal point, active high.
REQ-011 SHALL have port dig_sel, output, 4 bits: one-hot or zero digit enable, active high.
REQ-012 SHALL have port upd, output, 1 bit: one-cycle pulse when the shadow value is applied to the display.

Function
REQ-013 SHALL use a prescaler that counts 0..SCAN_DIV-1 while ena=1; tick = (count==SCAN_DIV-1), and the count wraps to 0 on tick.
REQ-014 SHALL advance a 2-bit digit pointer ptr on tick, 0->1->2->3->0.
REQ-015 SHALL treat a tick with ptr==3 as the frame boundary.
REQ-016 SHALL, on load=1 with ena=1, set shadow<=value and pending<=1; load with ena=0 is ignored.
REQ-017 SHALL, at the frame boundary with pending=1, set disp<=shadow, clear pending and assert upd for exactly the following cycle.
REQ-018 SHALL, when load coincides with the frame boundary, give disp the old shadow, give shadow the new value, and leave pending=1.
REQ-019 SHALL, at the frame boundary with pending=0, leave disp unchanged and keep upd=0.
REQ-020 SHALL register seg, dp and dig_sel with one cycle of latency from ptr and disp.
REQ-021 SHALL, in the cycle after a tick, drive dig_sel=0, seg=0 and dp=0 (anti-ghost gap); in every other enabled cycle it drives dig_sel=1<<ptr.
REQ-022 SHALL set seg to the hex pattern of disp nibble ptr: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-023 SHALL blank digit i (seg=0, dig_sel still asserted) when blank_lz=1, i!=0, and disp nibbles i..3 are all zero; digit 0 is never blanked.
REQ-024 SHALL set dp=dp_mask[ptr] during non-gap cycles, including cycles where the digit is blanked.
REQ-025 SHALL, while ena=0, hold prescaler, ptr, shadow, disp and pending, and drive seg=0, dp=0, dig_sel=0, upd=0 from the next cycle.
REQ-026 SHALL, on ena rising, resume from the held count and ptr with no gap cycle unless a tick occurs.
REQ-027 SHALL sample blank_lz and dp_mask live, not shadowed.

Reset
REQ-028 SHALL, on a clk edge with rst_n=0, clear prescaler, ptr, shadow, disp, pending, seg, dp, dig_sel and upd to 0.
REQ-029 SHALL abort any pending update when reset asserts mid-frame; the display shows 0000 after reset.
REQ-030 SHALL drive dig_sel=0001 and seg=3F in the first cycle after rst_n=1 when ena=1.

Structure
REQ-031 SHALL place the segment code constants and the NDIG=4 constant in a shared package seg7_pkg.
REQ-032 SHALL instantiate one combinational sub-module seg7_hex_lut (4-bit nibble in, 7-bit pattern out).
REQ-033 SHALL contain no latches and no second clock or derived clock.

Verification (SCAN_DIV=4, ena=1, blank_lz=0 unless stated)
REQ-034 SHALL cover: release reset -> dig_sel sequence 0001,0000,0010,0000,0100,0000,1000,0000 with each non-zero state held for 3 cycles, and seg=3F on every non-gap cycle.
REQ-035 SHALL cover: load value=16'h12AF mid-frame -> display unchanged until the frame boundary, upd pulses once, then digits 0..3 show 71,77,5B,06.
REQ-036 SHALL cover: blank_lz=1, value=16'h0040 -> digits 3 and 2 show seg=0, digit 1 shows 66, digit 0 shows 3F; with value=0, only digit 0 shows 3F.
REQ-037 SHALL cover: load=1 on the frame-boundary cycle -> disp takes the previous shadow, and the new value appears one frame later with a second upd pulse.
REQ-038 SHALL cover: ena=0 for 10 cycles mid-slot -> outputs 0, ptr/count frozen; after resume the slot completes its remaining cycles.
REQ-039 SHALL cover: rst_n=0 while pending=1, dp_mask=4'b0100 -> after release, display 0000 and upd never pulses; dp=1 only while dig_sel=0100.
